// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// The optional clear sweep is controlled by REG_ARB_CLEAR_EN (see reg_write_arbiter).
package reg_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF = 32'd3;
  localparam int DW_DEF   = 32'd8;
  localparam int PW_DEF   = 32'd4;

  // Next index in round-robin order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return ((cur + 32'd1) >= n) ? 32'd0 : (cur + 32'd1);
  endfunction

  // Width needed to hold an index in 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational one-hot round-robin picker: the first requester after `last`
// (in wrapping order) that asserts req wins.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [LW-1:0]   idx,
  output logic            any
);

  // Scan NREQ candidates starting just after the previous winner.
  always_comb begin
    logic [LW-1:0] c_s;
    logic          hit_s;
    gnt   = '0;
    idx   = last;
    any   = 1'b0;
    c_s   = last;
    hit_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      c_s      = LW'(rr_next(32'(c_s), NREQ));
      hit_s    = req[c_s] & ~any;
      gnt[c_s] = gnt[c_s] | hit_s;
      idx      = hit_s ? c_s : idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with an optional
// runtime clear sweep enabled by defining REG_ARB_CLEAR_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int pw   = PW_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][pw-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_dat,
  output logic [NREQ-1:0]          gnt,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     wr_en,
  output logic [pw-1:0]            wr_addr,
  output logic [DW-1:0]            wr_dat
);

  localparam int            LW       = idx_width(NREQ);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  logic [LW-1:0]   last_r;
  logic [LW-1:0]   pick_idx_s;
  logic [NREQ-1:0] pick_gnt_s;
  logic            pick_any_s;
  logic            grant_ok_s;
  logic            win_s;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_rr_pick (
    .req  (req),
    .last (last_r),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Expose the picker's choice only when the write port is free to take it.
  always_comb begin
    win_s = grant_ok_s & pick_any_s;
    if (grant_ok_s) begin
      gnt = pick_gnt_s;
    end else begin
      gnt = '0;
    end
  end

`ifdef REG_ARB_CLEAR_EN

  localparam logic [pw-1:0] CNT_MAX = {pw{1'b1}};

  arb_state_t    state_r;
  logic [pw-1:0] cnt_r;

  // A sweep request in IDLE pre-empts every requester that cycle.
  always_comb begin
    if (reset) begin
      grant_ok_s = 1'b0;
    end else if (state_r == IDLE) begin
      grant_ok_s = ~clr_start;
    end else begin
      grant_ok_s = 1'b0;
    end
  end

  // Arbitration / sweep FSM; cnt_r is the address currently being cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      last_r   <= LAST_RST;
      clr_busy <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_dat   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clr_start) begin
            state_r  <= CLEAR;
            cnt_r    <= '0;
            clr_busy <= 1'b1;
            wr_en    <= 1'b1;
            wr_addr  <= '0;
            wr_dat   <= '0;
          end else if (win_s) begin
            last_r  <= pick_idx_s;
            wr_en   <= 1'b1;
            wr_addr <= req_addr[pick_idx_s];
            wr_dat  <= req_dat[pick_idx_s];
          end else begin
            wr_en <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_r == CNT_MAX) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            clr_busy <= 1'b0;
            wr_en    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= cnt_r + 1'b1;
            wr_dat  <= '0;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          clr_busy <= 1'b0;
          wr_en    <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_clr_start_s;

  assign unused_clr_start_s = clr_start;
  assign clr_busy           = 1'b0;

  // Without the sweep the block is permanently arbitrating.
  always_comb begin
    if (reset) begin
      grant_ok_s = 1'b0;
    end else begin
      grant_ok_s = 1'b1;
    end
  end

  // Register the winning write; addr/data hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r  <= LAST_RST;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else if (win_s) begin
      last_r  <= pick_idx_s;
      wr_en   <= 1'b1;
      wr_addr <= req_addr[pick_idx_s];
      wr_dat  <= req_dat[pick_idx_s];
    end else begin
      wr_en <= 1'b0;
    end
  end

`endif

endmodule
